// File: rtl/lfsr_pkg.sv
// lfsr_pkg: checker state encoding and the noise polynomial step shared with the generator.
package lfsr_pkg;
    localparam int MAX_W = 64;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} chk_state_e;
    function automatic logic [MAX_W-1:0] step(input logic [MAX_W-1:0] s, input int w);
        logic fb;
        fb = s[w-1] ^ s[w/2] ^ s[w/3] ^ s[0];
        return ((s << 1) | MAX_W'(fb)) & ({MAX_W{1'b1}} >> (MAX_W - w));
    endfunction
endpackage

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a full-width LFSR noise stream and counts sample errors once locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LFSR_WIDTH = 24,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [LFSR_WIDTH-1:0] i_data,
    input  logic                  i_clr,
    output logic                  o_locked,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    chk_state_e state_q, state_d;
    logic [LFSR_WIDTH-1:0] ref_q, ref_d, exp_w;
    logic [MW-1:0] match_q, match_d;
    logic [LW-1:0] miss_q, miss_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic locked_q, err_q, err_d, hit;
    assign exp_w = LFSR_WIDTH'(step(MAX_W'(ref_q), LFSR_WIDTH));
    assign hit = i_data == exp_w;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= SEARCH;
            ref_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            cnt_q    <= cnt_d;
            locked_q <= state_d == LOCKED;
            err_q    <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (i_valid) begin
            case (state_q)
                SEARCH: begin
                    if (i_data != '0) begin
                        ref_d   = i_data;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    ref_d   = i_data;
                    match_d = hit ? match_q + 1'b1 : '0;
                    if (hit && match_d == MW'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end else if (!hit && i_data == '0) begin
                        state_d = SEARCH;
                    end
                end
                default: begin
                    // Flywheel: the reference free-runs so single corrupt words cannot derail it.
                    ref_d  = exp_w;
                    miss_d = hit ? '0 : miss_q + 1'b1;
                    if (!hit && miss_d == LW'(LOSS_CNT)) state_d = SEARCH;
                end
            endcase
        end
    end
    always_comb begin
        err_d = i_valid && state_q == LOCKED && !hit;
        cnt_d = i_clr ? '0 : (err_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    assign o_locked  = locked_q;
    assign o_err     = err_q;
    assign o_err_cnt = cnt_q;
endmodule
